// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared fetch-stage types, the D-register layout and the reset PC constant.
package fetch_unit_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} fetch_state_t;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] valP;
    logic        adel;
  } d_reg_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry {instr, pc, adel} register with a bypass/buffered output select.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        sel_buf,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        in_adel,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_adel
);
  logic [31:0] instr_q, instr_d, pc_q, pc_d;
  logic        adel_q, adel_d;
  always_comb begin
    instr_d = load ? in_instr : instr_q;
    pc_d    = load ? in_pc : pc_q;
    adel_d  = load ? in_adel : adel_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      adel_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      adel_q  <= adel_d;
    end
  end
  assign out_instr = sel_buf ? instr_q : in_instr;
  assign out_pc    = sel_buf ? pc_q : in_pc;
  assign out_adel  = sel_buf ? adel_q : in_adel;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, single-outstanding instruction-bus handshake, stall buffer and delay-slot redirects.
// FETCH_ALIGN_CHECK_EN: misaligned PCs produce one adel nop instead of a bus request.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_valP,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_adel
);
  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, inflight_pc_q, inflight_pc_d, pend_pc_q, pend_pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic         buf_load, misaligned, in_adel, buf_adel, adel_out;
  logic [31:0]  in_instr, in_pc, buf_instr, buf_pc;
  d_reg_t       d_out;

`ifdef FETCH_ALIGN_CHECK_EN
  logic spent_q, spent_d;
  assign misaligned = pc_q[1:0] != 2'b00;
  assign ireq_addr  = pc_q;
  // An adel nop is offered once, then fetch idles in HOLD until redirected.
  assign spent_d    = state_q == HOLD && state_d == HOLD && buf_adel && (spent_q || out_ready);
  assign out_valid  = (state_q == WAIT && iresp_data_ok) || (state_q == HOLD && !(buf_adel && spent_q));
  assign adel_out   = out_valid && buf_adel;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) spent_q <= 1'b0;
    else spent_q <= spent_d;
  end
`else
  assign misaligned = 1'b0;
  assign ireq_addr  = {pc_q[31:2], 2'b00};
  assign out_valid  = (state_q == WAIT && iresp_data_ok) || state_q == HOLD;
  assign adel_out   = 1'b0;
`endif

  assign ireq_valid = state_q == REQ && !reset && !misaligned;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_pc_d     = pend_pc_q;
    buf_load      = 1'b0;
    in_instr      = iresp_data;
    in_pc         = inflight_pc_q;
    in_adel       = 1'b0;
    case (state_q)
      REQ: begin
        if (misaligned) begin
          if (redirect_valid) pc_d = redirect_pc;
          else begin
            buf_load = 1'b1;
            in_instr = '0;
            in_pc    = pc_q;
            in_adel  = 1'b1;
            state_d  = HOLD;
          end
        end else if (ireq_addr_ok) begin
          inflight_pc_d = pc_q;
          pc_d          = redirect_valid ? redirect_pc : pend_valid_q ? pend_pc_q : pc_q + 32'd4;
          pend_valid_d  = 1'b0;
          state_d       = WAIT;
        end else if (redirect_valid) begin
          // The delay-slot address is already on the bus; park the target until it is accepted.
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
      end
      WAIT: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (iresp_data_ok) begin
          buf_load = !out_ready;
          state_d  = out_ready ? REQ : HOLD;
        end
      end
      default: begin
        if (redirect_valid) pc_d = redirect_pc;
        state_d = buf_adel ? (redirect_valid ? REQ : HOLD) : (out_ready ? REQ : HOLD);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= REQ;
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk      (clk),
    .reset    (reset),
    .load     (buf_load),
    .sel_buf  (state_q == HOLD),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .in_adel  (in_adel),
    .out_instr(buf_instr),
    .out_pc   (buf_pc),
    .out_adel (buf_adel)
  );

  assign d_out     = '{instr: buf_instr, pc: buf_pc, valP: buf_pc + 32'd4, adel: adel_out};
  assign out_instr = d_out.instr;
  assign out_pc    = d_out.pc;
  assign out_valP  = d_out.valP;
  assign out_adel  = d_out.adel;
endmodule
